// File: rtl/iter_shift8_if.sv
// Request/result bundle for the iterative 8-bit right shifter.
// The consumer drives the request side; the shifter drives the result side.
interface iter_shift8_if;
  logic       start;
  logic       mode;
  logic [7:0] d_in;
  logic [3:0] shamt;
  logic [7:0] d_out;
  logic       busy;
  logic       done;

  modport master (output start, mode, d_in, shamt, input d_out, busy, done);
  modport slave  (input start, mode, d_in, shamt, output d_out, busy, done);
endinterface

// File: rtl/iter_shift8.sv
// Multi-cycle 8-bit right shifter: retires up to 3 positions per clock with
// logical or arithmetic fill, reporting progress through busy/done.
module iter_shift8 (
  input  logic          clk,
  input  logic          reset_n,
  iter_shift8_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_data;
  logic [3:0]  r_rem;
  logic        r_mode;

  logic        w_accept;
  logic [1:0]  w_step;
  logic [3:0]  w_rem_next;
  logic [3:0]  w_rem_load;
  logic [10:0] w_ext;
  logic [10:0] w_ext_sh;

  // A request is honoured whenever no shift is in progress, so DONE can
  // chain straight into the next operation without an idle cycle.
  assign w_accept   = bus.start && (r_state != S_SHIFT);
  assign w_rem_load = bus.shamt[3] ? 4'd8 : bus.shamt;
  assign w_step     = (r_rem >= 4'd3) ? 2'd3 : r_rem[1:0];
  assign w_rem_next = r_rem - {2'b00, w_step};

  // Three fill bits above the operand cover the largest single-cycle step.
  assign w_ext    = {{3{r_mode & r_data[7]}}, r_data};
  assign w_ext_sh = w_ext >> w_step;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_SHIFT;
      S_SHIFT: if (w_rem_next == 4'd0) w_next = S_DONE;
      S_DONE:  if (w_accept) w_next = S_SHIFT;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy  = (r_state == S_SHIFT);
    bus.done  = (r_state == S_DONE);
    bus.d_out = r_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= 8'h00;
      r_rem  <= 4'd0;
      r_mode <= 1'b0;
    end else if (w_accept) begin
      r_data <= bus.d_in;
      r_rem  <= w_rem_load;
      r_mode <= bus.mode;
    end else if (r_state == S_SHIFT) begin
      r_data <= w_ext_sh[7:0];
      r_rem  <= w_rem_next;
    end
  end
endmodule

// File: tb/tb_iter_shift8.sv
// Self-checking bench for iter_shift8: directed table, random operations
// against a cumulative-shift model, and handshake/reset corner sequences.
module tb_iter_shift8;
  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  iter_shift8_if u_if ();

  iter_shift8 u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        m;
    logic [7:0]  d;
    logic [3:0]  s;
    logic [23:0] trace;   // d_out after shift edge k in byte k-1
    int          cycles;
  } vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Reference: after k shift cycles the operand has moved min(3k, r) places.
  function automatic logic [7:0] ref_shift(input logic m, input logic [7:0] d, input int amt);
    logic signed [7:0] s;
    s = d;
    if (m) return 8'(s >>> amt);
    return 8'(d >> amt);
  endfunction

  function automatic int ref_cycles(input int r);
    return (r == 0) ? 1 : (r + 2) / 3;
  endfunction

  task automatic issue(input logic m, input logic [7:0] d, input logic [3:0] s);
    @(negedge clk);
    u_if.start = 1'b1;
    u_if.mode  = m;
    u_if.d_in  = d;
    u_if.shamt = s;
    @(negedge clk);
    u_if.start = 1'b0;
    check("accept_busy", 8'(u_if.busy), 8'd1);
    check("accept_done", 8'(u_if.done), 8'd0);
    check("accept_data", u_if.d_out, d);
  endtask

  task automatic check_run(input string name, input logic [23:0] trace, input int cycles);
    for (int k = 1; k <= cycles; k++) begin
      if (k > 1) @(negedge clk);
      check({name, "_dout"}, u_if.d_out, trace[(k-1)*8 +: 8]);
      check({name, "_busy"}, 8'(u_if.busy), 8'(k < cycles));
      check({name, "_done"}, 8'(u_if.done), 8'(k == cycles));
    end
  endtask

  task automatic model_trace(input logic m, input logic [7:0] d, input logic [3:0] s,
                             output logic [23:0] trace, output int cycles);
    int r;
    r      = (s > 4'd8) ? 8 : int'(s);
    cycles = ref_cycles(r);
    trace  = '0;
    for (int k = 1; k <= cycles; k++)
      trace[(k-1)*8 +: 8] = ref_shift(m, d, (3*k < r) ? 3*k : r);
  endtask

  vec_t vecs[8];

  initial begin
    logic [23:0] tr;
    int          cyc;
    logic        m;
    logic [7:0]  d;
    logic [3:0]  s;

    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    u_if.start = 1'b0;
    u_if.mode  = 1'b0;
    u_if.d_in  = 8'h00;
    u_if.shamt = 4'd0;

    vecs[0] = '{1'b0, 8'hB5, 4'd5,  {8'h00, 8'h05, 8'h16}, 2};
    vecs[1] = '{1'b1, 8'h80, 4'd8,  {8'hFF, 8'hFE, 8'hF0}, 3};
    vecs[2] = '{1'b1, 8'h80, 4'd13, {8'hFF, 8'hFE, 8'hF0}, 3};
    vecs[3] = '{1'b0, 8'h3C, 4'd0,  {8'h00, 8'h00, 8'h3C}, 1};
    vecs[4] = '{1'b0, 8'hFF, 4'd12, {8'h00, 8'h03, 8'h1F}, 3};
    vecs[5] = '{1'b1, 8'hB5, 4'd1,  {8'h00, 8'h00, 8'hDA}, 1};
    vecs[6] = '{1'b0, 8'hB5, 4'd3,  {8'h00, 8'h00, 8'h16}, 1};
    vecs[7] = '{1'b1, 8'h7F, 4'd7,  {8'h00, 8'h01, 8'h0F}, 3};

    repeat (2) @(negedge clk);
    check("reset_dout", u_if.d_out, 8'h00);
    check("reset_busy", 8'(u_if.busy), 8'd0);
    check("reset_done", 8'(u_if.done), 8'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", 8'(u_if.busy), 8'd0);
    check("idle_done", 8'(u_if.done), 8'd0);

    foreach (vecs[i]) begin
      issue(vecs[i].m, vecs[i].d, vecs[i].s);
      @(negedge clk);
      check_run($sformatf("vec%0d", i), vecs[i].trace, vecs[i].cycles);
      @(negedge clk);
      check($sformatf("vec%0d_hold", i), u_if.d_out, vecs[i].trace[(vecs[i].cycles-1)*8 +: 8]);
    end

    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom);
      d = 8'($urandom);
      s = 4'($urandom);
      model_trace(m, d, s, tr, cyc);
      issue(m, d, s);
      @(negedge clk);
      check_run($sformatf("rnd%0d", i), tr, cyc);
    end

    // Request with new operands while busy is ignored.
    model_trace(1'b0, 8'hB5, 4'd8, tr, cyc);
    issue(1'b0, 8'hB5, 4'd8);
    u_if.start = 1'b1;
    u_if.mode  = 1'b1;
    u_if.d_in  = 8'hFF;
    u_if.shamt = 4'd1;
    @(negedge clk);
    check("ign_dout1", u_if.d_out, tr[7:0]);
    check("ign_busy1", 8'(u_if.busy), 8'd1);
    @(negedge clk);
    u_if.start = 1'b0;
    check("ign_dout2", u_if.d_out, tr[15:8]);
    @(negedge clk);
    check("ign_dout3", u_if.d_out, tr[23:16]);
    check("ign_done", 8'(u_if.done), 8'd1);

    // Start held high: DONE chains straight into the next operation.
    @(negedge clk);
    u_if.start = 1'b1;
    u_if.mode  = 1'b0;
    u_if.d_in  = 8'hF0;
    u_if.shamt = 4'd4;
    @(negedge clk);
    check("b2b_a_busy", 8'(u_if.busy), 8'd1);
    u_if.mode  = 1'b1;
    u_if.d_in  = 8'hC0;
    u_if.shamt = 4'd2;
    @(negedge clk);
    check("b2b_a_dout1", u_if.d_out, 8'h1E);
    @(negedge clk);
    check("b2b_a_dout2", u_if.d_out, 8'h0F);
    check("b2b_a_done", 8'(u_if.done), 8'd1);
    @(negedge clk);
    check("b2b_b_busy", 8'(u_if.busy), 8'd1);
    check("b2b_b_done", 8'(u_if.done), 8'd0);
    check("b2b_b_load", u_if.d_out, 8'hC0);
    @(negedge clk);
    u_if.start = 1'b0;
    check("b2b_b_dout", u_if.d_out, 8'hF0);
    check("b2b_b_done2", 8'(u_if.done), 8'd1);

    // Asynchronous reset between clock edges, mid-shift.
    issue(1'b0, 8'hFF, 4'd8);
    @(negedge clk);
    check("pre_rst_busy", 8'(u_if.busy), 8'd1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_dout", u_if.d_out, 8'h00);
    check("arst_busy", 8'(u_if.busy), 8'd0);
    check("arst_done", 8'(u_if.done), 8'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_dout", u_if.d_out, 8'h00);
    check("post_rst_busy", 8'(u_if.busy), 8'd0);
    check("post_rst_done", 8'(u_if.done), 8'd0);
    model_trace(1'b1, 8'h96, 4'd6, tr, cyc);
    issue(1'b1, 8'h96, 4'd6);
    @(negedge clk);
    check_run("post_rst_op", tr, cyc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
